// File: rtl/codificador_maq.sv
// codificador_maq
// Sends a framed character sequence to a downstream consumer over a
// valid/accept handshake. A start request sends C1..CN (N = Comprimento,
// 1..5), followed by a terminator: C6 for N = 1..3, C8 for N = 4..5.
// GAP idle cycles can be inserted between consecutive characters. An abort
// replaces the pending character with C7 and ends the message without a
// completion pulse.
//
// Parameters
//   GAP         : number of idle cycles between consecutive characters
//   CHAR_OCIOSO : value driven on Saida whenever Valido is low
// Ports
//   clk         : clock; all state changes happen on its rising edge
//   Reset       : asynchronous reset, active low
//   Inicio      : start request, only honoured while idle
//   Comprimento : sequence length, sampled together with Inicio
//   Abortar     : cancel the message in progress
//   Aceite      : consumer ready; a character moves when Valido & Aceite
//   Saida       : character being offered
//   Valido      : Saida holds a character
//   Controle    : copy of Ocupado, drives the decoder enable
//   Ocupado     : a message is in progress
//   Concluido   : one-cycle pulse when a message completes normally
//   Erro        : one-cycle pulse when a start request is rejected
module codificador_maq #(
  parameter int         GAP         = 0,
  parameter logic [6:0] CHAR_OCIOSO = 7'b0000000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Inicio,
  input  logic [2:0] Comprimento,
  input  logic       Abortar,
  input  logic       Aceite,
  output logic [6:0] Saida,
  output logic       Valido,
  output logic       Controle,
  output logic       Ocupado,
  output logic       Concluido,
  output logic       Erro
);

  // Gap counter must hold GAP; keep at least one bit when GAP is 0.
  localparam int          GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  localparam logic [6:0] C1 = 7'b1100000;
  localparam logic [6:0] C2 = 7'b1000100;
  localparam logic [6:0] C3 = 7'b1111100;
  localparam logic [6:0] C4 = 7'b1011010;
  localparam logic [6:0] C5 = 7'b1101110;
  localparam logic [6:0] C6 = 7'b1001001;
  localparam logic [6:0] C7 = 7'b1110101;
  localparam logic [6:0] C8 = 7'b1010011;

  typedef enum logic [2:0] {
    OCIOSO,
    ENVIA,
    PAUSA,
    TERMINA,
    ABORTA
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      n_q, n_d;
  logic [2:0]      k_q, k_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            fim_q, fim_d;
  logic            conc_q, conc_d;
  logic            erro_q, erro_d;
  logic            transfer;
  logic            lenOk;

  assign transfer = Valido & Aceite;
  assign lenOk    = (Comprimento != 3'd0) && (Comprimento <= 3'd5);

  // fim_q remembers that the pause in progress is the one before the
  // terminator, so the index counter never has to run past N.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    gap_d   = gap_q;
    fim_d   = fim_q;
    conc_d  = 1'b0;
    erro_d  = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (Inicio) begin
          if (lenOk) begin
            n_d     = Comprimento;
            k_d     = 3'd1;
            fim_d   = 1'b0;
            state_d = ENVIA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      ENVIA: begin
        // An abort wins whether or not the current character moved; a
        // character that did move is simply considered sent.
        if (Abortar) begin
          state_d = ABORTA;
        end else if (transfer) begin
          if (k_q == n_q) begin
            if (GAP == 0) begin
              state_d = TERMINA;
            end else begin
              fim_d   = 1'b1;
              gap_d   = GAP_LOAD;
              state_d = PAUSA;
            end
          end else begin
            k_d = k_q + 3'd1;
            if (GAP != 0) begin
              gap_d   = GAP_LOAD;
              state_d = PAUSA;
            end
          end
        end
      end
      PAUSA: begin
        if (Abortar) begin
          state_d = ABORTA;
        end else if (gap_q <= GW'(1)) begin
          state_d = fim_q ? TERMINA : ENVIA;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      TERMINA: begin
        if (Abortar) begin
          state_d = ABORTA;
        end else if (transfer) begin
          conc_d  = 1'b1;
          state_d = OCIOSO;
        end
      end
      ABORTA: begin
        if (transfer) begin
          state_d = OCIOSO;
        end
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= OCIOSO;
      n_q     <= 3'd0;
      k_q     <= 3'd0;
      gap_q   <= '0;
      fim_q   <= 1'b0;
      conc_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      fim_q   <= fim_d;
      conc_q  <= conc_d;
      erro_q  <= erro_d;
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    Ocupado   = (state_q != OCIOSO);
    Controle  = Ocupado;
    Valido    = (state_q == ENVIA) || (state_q == TERMINA) || (state_q == ABORTA);
    Concluido = conc_q;
    Erro      = erro_q;
    Saida     = CHAR_OCIOSO;
    case (state_q)
      ENVIA: begin
        case (k_q)
          3'd1:    Saida = C1;
          3'd2:    Saida = C2;
          3'd3:    Saida = C3;
          3'd4:    Saida = C4;
          3'd5:    Saida = C5;
          default: Saida = CHAR_OCIOSO;
        endcase
      end
      TERMINA: Saida = (n_q <= 3'd3) ? C6 : C8;
      ABORTA:  Saida = C7;
      default: Saida = CHAR_OCIOSO;
    endcase
  end

endmodule
